// File: rtl/spsram_arb_pkg.sv
// Shared definitions for the two-requester single-port SRAM arbiter.
package spsram_arb_pkg;

    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LAST0 = 2'd1,
        LAST1 = 2'd2
    } arb_state_e;

    // Round-robin winner under contention: requester 1 only right after requester 0 was served.
    function automatic logic [NUM_REQ-1:0] rr_winner(arb_state_e st);
        return (st == LAST0) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/spsram.sv
// Single-port SRAM model; read data is registered unless SPSRAM_ASYNC is defined.
module spsram #(
    parameter int unsigned BW_DATA = 32,
    parameter int unsigned BW_ADDR = 8
) (
    input  logic               i_clk,
    input  logic               i_cen,
    input  logic               i_wen,
    input  logic               i_oen,
    input  logic [BW_ADDR-1:0] i_addr,
    input  logic [BW_DATA-1:0] i_wdata,
    output logic [BW_DATA-1:0] o_rdata
);

    localparam int unsigned DEPTH = 1 << BW_ADDR;

    logic [BW_DATA-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_cen && i_wen) begin
            mem[i_addr] <= i_wdata;
        end
    end

`ifdef SPSRAM_ASYNC
    assign o_rdata = (i_cen && i_oen) ? mem[i_addr] : '0;
`else
    logic [BW_DATA-1:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_cen && i_oen) begin
            rdata_q <= mem[i_addr];
        end
    end

    assign o_rdata = rdata_q;
`endif

endmodule

// File: rtl/spsram_arb_core.sv
// Grant logic and last-winner FSM. Define SPSRAM_ARB_RR_EN for round-robin on contention,
// otherwise requester 0 has fixed priority.
import spsram_arb_pkg::*;

module spsram_arb_core (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_gnt
);

    arb_state_e state_q;

    always_comb begin
        o_gnt = '0;
        if (i_rstn) begin
            case (i_req)
                2'b01: o_gnt = 2'b01;
                2'b10: o_gnt = 2'b10;
`ifdef SPSRAM_ARB_RR_EN
                2'b11: o_gnt = rr_winner(state_q);
`else
                2'b11: o_gnt = 2'b01;
`endif
                default: o_gnt = '0;
            endcase
        end
    end

    // State only moves on a grant; idle cycles keep the last winner.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= IDLE;
        end else if (o_gnt[0]) begin
            state_q <= LAST0;
        end else if (o_gnt[1]) begin
            state_q <= LAST1;
        end
    end

endmodule

// File: rtl/spsram_arb.sv
// Two-requester arbiter in front of a single-port SRAM with registered read data.
// Round-robin contention resolution is enabled by defining SPSRAM_ARB_RR_EN.
import spsram_arb_pkg::*;

module spsram_arb #(
    parameter int unsigned BW_DATA = 32,
    parameter int unsigned BW_ADDR = 8
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic [1:0]         i_req,
    input  logic [1:0]         i_we,
    input  logic [BW_ADDR-1:0] i_addr0,
    input  logic [BW_ADDR-1:0] i_addr1,
    input  logic [BW_DATA-1:0] i_wdata0,
    input  logic [BW_DATA-1:0] i_wdata1,
    output logic [1:0]         o_gnt,
    output logic [1:0]         o_rvalid,
    output logic [BW_DATA-1:0] o_rdata,
    output logic               o_sram_cen,
    output logic               o_sram_wen,
    output logic               o_sram_oen,
    output logic [BW_ADDR-1:0] o_sram_addr,
    output logic [BW_DATA-1:0] o_sram_wdata,
    input  logic [BW_DATA-1:0] i_sram_rdata
);

    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] rsp_d;
    logic [NUM_REQ-1:0] rsp_q;

    spsram_arb_core u_core (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_req  (i_req),
        .o_gnt  (gnt)
    );

    assign o_gnt = gnt;

    always_comb begin
        o_sram_cen   = 1'b0;
        o_sram_wen   = 1'b0;
        o_sram_oen   = 1'b0;
        o_sram_addr  = '0;
        o_sram_wdata = '0;
        if (gnt[0]) begin
            o_sram_cen   = 1'b1;
            o_sram_wen   = i_we[0];
            o_sram_oen   = ~i_we[0];
            o_sram_addr  = i_addr0;
            o_sram_wdata = i_wdata0;
        end else if (gnt[1]) begin
            o_sram_cen   = 1'b1;
            o_sram_wen   = i_we[1];
            o_sram_oen   = ~i_we[1];
            o_sram_addr  = i_addr1;
            o_sram_wdata = i_wdata1;
        end
    end

    // Response tag: which requester owns the SRAM read data arriving next cycle.
    assign rsp_d = gnt & i_req & ~i_we;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            rsp_q <= '0;
        end else begin
            rsp_q <= rsp_d;
        end
    end

    // Masked by reset so a response caught by reset never becomes visible.
    assign o_rvalid = rsp_q & {NUM_REQ{i_rstn}};
    assign o_rdata  = i_sram_rdata;

endmodule

// File: tb/tb_spsram_arb.sv
// Directed bench for spsram_arb with a registered-read spsram behind it.
module tb_spsram_arb;
    import spsram_arb_pkg::*;

    localparam int unsigned BW_DATA = 32;
    localparam int unsigned BW_ADDR = 8;

    logic               clk = 1'b0;
    logic               rstn;
    logic [1:0]         req;
    logic [1:0]         we;
    logic [BW_ADDR-1:0] addr0;
    logic [BW_ADDR-1:0] addr1;
    logic [BW_DATA-1:0] wdata0;
    logic [BW_DATA-1:0] wdata1;
    logic [1:0]         gnt;
    logic [1:0]         rvalid;
    logic [BW_DATA-1:0] rdata;
    logic               sram_cen;
    logic               sram_wen;
    logic               sram_oen;
    logic [BW_ADDR-1:0] sram_addr;
    logic [BW_DATA-1:0] sram_wdata;
    logic [BW_DATA-1:0] sram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spsram_arb #(
        .BW_DATA (BW_DATA),
        .BW_ADDR (BW_ADDR)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_req        (req),
        .i_we         (we),
        .i_addr0      (addr0),
        .i_addr1      (addr1),
        .i_wdata0     (wdata0),
        .i_wdata1     (wdata1),
        .o_gnt        (gnt),
        .o_rvalid     (rvalid),
        .o_rdata      (rdata),
        .o_sram_cen   (sram_cen),
        .o_sram_wen   (sram_wen),
        .o_sram_oen   (sram_oen),
        .o_sram_addr  (sram_addr),
        .o_sram_wdata (sram_wdata),
        .i_sram_rdata (sram_rdata)
    );

    spsram #(
        .BW_DATA (BW_DATA),
        .BW_ADDR (BW_ADDR)
    ) u_sram (
        .i_clk   (clk),
        .i_cen   (sram_cen),
        .i_wen   (sram_wen),
        .i_oen   (sram_oen),
        .i_addr  (sram_addr),
        .i_wdata (sram_wdata),
        .o_rdata (sram_rdata)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] w,
                         input logic [BW_ADDR-1:0] a0, input logic [BW_ADDR-1:0] a1,
                         input logic [BW_DATA-1:0] d0, input logic [BW_DATA-1:0] d1);
        req    = r;
        we     = w;
        addr0  = a0;
        addr1  = a1;
        wdata0 = d0;
        wdata1 = d1;
        #1;
    endtask

    logic [1:0] exp_g;
    logic [1:0] prev_g;

    initial begin
        rstn = 1'b0;
        drive(2'b11, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
        check_eq("rst_gnt", 64'(gnt), 64'h0);
        check_eq("rst_cen", 64'(sram_cen), 64'h0);
        tick();
        check_eq("rst_rvalid", 64'(rvalid), 64'h0);
        check_eq("rst_state", 64'(dut.u_core.state_q), 64'(IDLE));
        tick();
        rstn = 1'b1;

        // Single write then read by requester 0
        drive(2'b01, 2'b01, 8'h10, 8'h00, 32'hDEADBEEF, 32'h0);
        check_eq("wr0_gnt", 64'(gnt), 64'h1);
        check_eq("wr0_cen", 64'(sram_cen), 64'h1);
        check_eq("wr0_wen", 64'(sram_wen), 64'h1);
        check_eq("wr0_oen", 64'(sram_oen), 64'h0);
        check_eq("wr0_addr", 64'(sram_addr), 64'h10);
        check_eq("wr0_wdata", 64'(sram_wdata), 64'hDEADBEEF);
        tick();
        check_eq("wr0_no_rvalid", 64'(rvalid), 64'h0);
        check_eq("wr0_state", 64'(dut.u_core.state_q), 64'(LAST0));
        drive(2'b01, 2'b00, 8'h10, 8'h00, 32'h0, 32'h0);
        check_eq("rd0_gnt", 64'(gnt), 64'h1);
        check_eq("rd0_wen", 64'(sram_wen), 64'h0);
        check_eq("rd0_oen", 64'(sram_oen), 64'h1);
        tick();
        drive(2'b00, 2'b00, 8'h10, 8'h00, 32'h0, 32'h0);
        check_eq("rd0_rvalid", 64'(rvalid), 64'h1);
        check_eq("rd0_rdata", 64'(rdata), 64'hDEADBEEF);
        check_eq("idle_gnt", 64'(gnt), 64'h0);
        check_eq("idle_cen", 64'(sram_cen), 64'h0);
        check_eq("idle_addr", 64'(sram_addr), 64'h0);
        tick();
        check_eq("rd0_rvalid_once", 64'(rvalid), 64'h0);
        check_eq("idle_state_hold", 64'(dut.u_core.state_q), 64'(LAST0));

        // Preload 0x20=0x11 via requester 1 and 0x21=0x22 via requester 0
        drive(2'b10, 2'b10, 8'h00, 8'h20, 32'h0, 32'h11);
        check_eq("wr1_gnt", 64'(gnt), 64'h2);
        check_eq("wr1_addr", 64'(sram_addr), 64'h20);
        check_eq("wr1_wdata", 64'(sram_wdata), 64'h11);
        tick();
        check_eq("wr1_state", 64'(dut.u_core.state_q), 64'(LAST1));
        drive(2'b01, 2'b01, 8'h21, 8'h00, 32'h22, 32'h0);
        tick();

        // Back-to-back reads, tagged to their issuers
        drive(2'b10, 2'b00, 8'h00, 8'h20, 32'h0, 32'h0);
        check_eq("b2b_gnt1", 64'(gnt), 64'h2);
        tick();
        drive(2'b01, 2'b00, 8'h21, 8'h20, 32'h0, 32'h0);
        check_eq("b2b_gnt0", 64'(gnt), 64'h1);
        check_eq("b2b_rvalid1", 64'(rvalid), 64'h2);
        check_eq("b2b_rdata1", 64'(rdata), 64'h11);
        tick();
        drive(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
        check_eq("b2b_rvalid0", 64'(rvalid), 64'h1);
        check_eq("b2b_rdata0", 64'(rdata), 64'h22);
        tick();
        check_eq("b2b_rvalid_clr", 64'(rvalid), 64'h0);

        // Contention from IDLE
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check_eq("cont_state_idle", 64'(dut.u_core.state_q), 64'(IDLE));
        drive(2'b11, 2'b00, 8'h10, 8'h20, 32'h0, 32'h0);
        prev_g = 2'b00;
        for (int i = 0; i < 4; i++) begin
`ifdef SPSRAM_ARB_RR_EN
            exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
            exp_g = 2'b01;
`endif
            check_eq($sformatf("cont_gnt%0d", i), 64'(gnt), 64'(exp_g));
            check_eq($sformatf("cont_rvalid%0d", i), 64'(rvalid), 64'(prev_g));
            if (prev_g != 2'b00) begin
                check_eq($sformatf("cont_rdata%0d", i), 64'(rdata),
                         (prev_g == 2'b01) ? 64'hDEADBEEF : 64'h11);
            end
            tick();
            prev_g = exp_g;
        end
        drive(2'b10, 2'b00, 8'h10, 8'h20, 32'h0, 32'h0);
        check_eq("cont_req1_after", 64'(gnt), 64'h2);
        check_eq("cont_rvalid_last", 64'(rvalid), 64'(prev_g));
        tick();
        drive(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
        check_eq("cont_rvalid_req1", 64'(rvalid), 64'h2);
        check_eq("cont_rdata_req1", 64'(rdata), 64'h11);
        tick();

        // Reset lands one edge after a read handshake
        drive(2'b01, 2'b00, 8'h10, 8'h20, 32'h0, 32'h0);
        check_eq("rstmid_gnt", 64'(gnt), 64'h1);
        tick();
        rstn = 1'b0;
        drive(2'b11, 2'b00, 8'h10, 8'h20, 32'h0, 32'h0);
        check_eq("rstmid_rvalid_a", 64'(rvalid), 64'h0);
        check_eq("rstmid_gnt_rst", 64'(gnt), 64'h0);
        check_eq("rstmid_cen_rst", 64'(sram_cen), 64'h0);
        tick();
        check_eq("rstmid_rvalid_b", 64'(rvalid), 64'h0);
        check_eq("rstmid_state", 64'(dut.u_core.state_q), 64'(IDLE));
        rstn = 1'b1;
        #1;
        check_eq("rstmid_cont_gnt", 64'(gnt), 64'h1);
        tick();
        check_eq("rstmid_rvalid_c", 64'(rvalid), 64'h1);
        check_eq("rstmid_rdata_c", 64'(rdata), 64'hDEADBEEF);
`ifdef SPSRAM_ARB_RR_EN
        check_eq("rstmid_cont_gnt2", 64'(gnt), 64'h2);
`else
        check_eq("rstmid_cont_gnt2", 64'(gnt), 64'h1);
`endif
        drive(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
